csr_file: RTL

Machine-mode CSR register file for the RV32IM pipelined core, sitting downstream of the decode/control stage at the commit point. It executes committed CSR read-modify-write instructions, performs trap entry on committed exceptions and trap return on committed MRET, and maintains the 64-bit cycle and retired-instruction counters. It also feeds `mstatus` and `mret_out` back to the control stage, which updates privilege from `mstatus[12:11]` when `mret_out` is high.

---
 rtl/csr_pkg.sv | 38 +++
 rtl/csr_counter64.sv | 33 +++
 rtl/csr_file.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/csr_pkg.sv
// csr_pkg: shared constants for the machine-mode CSR file.
//   CSR addresses, CSR funct3 encodings, mstatus bit positions and the
//   exception cause codes used by the core.
package csr_pkg;

    localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
    localparam logic [11:0] ADDR_MISA      = 12'h301;
    localparam logic [11:0] ADDR_MTVEC     = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
    localparam logic [11:0] ADDR_MEPC      = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
    localparam logic [11:0] ADDR_MTVAL     = 12'h343;
    localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
    localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
    localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
    localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;
    localparam logic [11:0] ADDR_MHARTID   = 12'hF14;

    typedef enum logic [2:0] {
        CSR_RW  = 3'b001,
        CSR_RS  = 3'b010,
        CSR_RC  = 3'b011,
        CSR_RWI = 3'b101,
        CSR_RSI = 3'b110,
        CSR_RCI = 3'b111
    } csr_op_e;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

    localparam logic [31:0] CAUSE_ILLEGAL_INSTR = 32'd2;
    localparam logic [31:0] CAUSE_BREAKPOINT    = 32'd3;
    localparam logic [31:0] CAUSE_ECALL_U       = 32'd8;
    localparam logic [31:0] CAUSE_ECALL_M       = 32'd11;

endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: wide counter with increment enable and separate lo/hi
// write ports. A write to either half suppresses the increment that cycle.
//   clk, rst      clock, synchronous active-high reset
//   inc_en        advance by one this cycle
//   lo_we, hi_we  replace the low / high half with wdata
//   wdata         write data for either half
//   count         current value
module csr_counter64 #(
    parameter int unsigned HALF_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    inc_en,
    input  logic                    lo_we,
    input  logic                    hi_we,
    input  logic [HALF_WIDTH-1:0]   wdata,
    output logic [2*HALF_WIDTH-1:0] count
);

    localparam int unsigned CW = 2 * HALF_WIDTH;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (lo_we || hi_we) begin
            if (lo_we) count[HALF_WIDTH-1:0]  <= wdata;
            if (hi_we) count[CW-1:HALF_WIDTH] <= wdata;
        end else if (inc_en) begin
            count <= count + CW'(1);
        end
    end

endmodule

// File: rtl/csr_file.sv
// csr_file: machine-mode CSR file at the commit point. Executes CSR
// read-modify-write ops, trap entry and MRET, and keeps mcycle/minstret.
//   commit_* / is_csr / csr_* / rs1_*   committing CSR instruction
//   exception_*                         committing trap
//   is_mret                             committing MRET
//   current_privilege                   current mode (11 M, 00 U)
//   csr_rdata, illegal_csr              combinational read / access check
//   trap_redirect, redirect_pc          combinational flush and target
//   mret_out                            combinational MRET indication
//   mstatus                             current mstatus
module csr_file
    import csr_pkg::*;
#(
    parameter int unsigned          DATA_WIDTH  = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_MTVEC = '0,
    parameter logic [DATA_WIDTH-1:0] MISA_VALUE  = 32'h4000_1100,
    parameter logic [DATA_WIDTH-1:0] HART_ID     = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  commit_valid,
    input  logic                  is_csr,
    input  logic [2:0]            csr_op,
    input  logic [11:0]           csr_addr,
    input  logic [4:0]            rs1_idx,
    input  logic [DATA_WIDTH-1:0] rs1_data,
    input  logic                  exception_valid,
    input  logic [DATA_WIDTH-1:0] exception_cause,
    input  logic [DATA_WIDTH-1:0] exception_pc,
    input  logic                  is_mret,
    input  logic [1:0]            current_privilege,
    output logic [DATA_WIDTH-1:0] csr_rdata,
    output logic                  illegal_csr,
    output logic                  trap_redirect,
    output logic [DATA_WIDTH-1:0] redirect_pc,
    output logic                  mret_out,
    output logic [DATA_WIDTH-1:0] mstatus
);

    localparam int unsigned W = DATA_WIDTH;

    logic            mie, mpie;
    logic [1:0]      mpp;
    logic [W-1:0]    mtvec, mscratch, mepc, mcause, mtval;
    logic [2*W-1:0]  mcycle_q, minstret_q;

    logic [W-1:0]    old_val, src, new_val;
    logic            known, write_attempt, csr_we;

    // mstatus view: only MIE, MPIE and MPP exist
    always_comb begin
        mstatus                                = '0;
        mstatus[MSTATUS_MIE]                   = mie;
        mstatus[MSTATUS_MPIE]                  = mpie;
        mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = mpp;
    end

    // Address decode and pre-write value
    always_comb begin
        old_val = '0;
        known   = 1'b1;
        case (csr_addr)
            ADDR_MSTATUS:   old_val = mstatus;
            ADDR_MISA:      old_val = MISA_VALUE;
            ADDR_MTVEC:     old_val = mtvec;
            ADDR_MSCRATCH:  old_val = mscratch;
            ADDR_MEPC:      old_val = mepc;
            ADDR_MCAUSE:    old_val = mcause;
            ADDR_MTVAL:     old_val = mtval;
            ADDR_MCYCLE:    old_val = mcycle_q[W-1:0];
            ADDR_MCYCLEH:   old_val = mcycle_q[2*W-1:W];
            ADDR_MINSTRET:  old_val = minstret_q[W-1:0];
            ADDR_MINSTRETH: old_val = minstret_q[2*W-1:W];
            ADDR_MHARTID:   old_val = HART_ID;
            default:        known   = 1'b0;
        endcase
    end

    // Read-modify-write data; set/clear ops with rs1 = x0 are pure reads
    always_comb begin
        src           = csr_op[2] ? W'(rs1_idx) : rs1_data;
        new_val       = old_val;
        write_attempt = 1'b0;
        case (csr_op_e'(csr_op))
            CSR_RW, CSR_RWI: begin
                new_val       = src;
                write_attempt = 1'b1;
            end
            CSR_RS, CSR_RSI: begin
                new_val       = old_val | src;
                write_attempt = (rs1_idx != 5'd0);
            end
            CSR_RC, CSR_RCI: begin
                new_val       = old_val & ~src;
                write_attempt = (rs1_idx != 5'd0);
            end
            default: ;
        endcase
    end

    assign illegal_csr = commit_valid && is_csr &&
                         (!known ||
                          (csr_addr[11:10] == 2'b11 && write_attempt) ||
                          (csr_addr[9:8] > current_privilege));

    // Trap and MRET both win over a CSR write in the same commit
    assign csr_we = commit_valid && is_csr && write_attempt && !illegal_csr &&
                    !exception_valid && !is_mret;

    assign csr_rdata     = (commit_valid && is_csr) ? old_val : '0;
    assign trap_redirect = commit_valid && (exception_valid || is_mret);
    assign mret_out      = commit_valid && is_mret && !exception_valid;
    assign redirect_pc   = (commit_valid && exception_valid) ? mtvec :
                           mret_out                          ? mepc  : '0;

    // Architectural state: trap > MRET > CSR write
    always_ff @(posedge clk) begin
        if (rst) begin
            mie      <= 1'b0;
            mpie     <= 1'b0;
            mpp      <= 2'b11;
            mtvec    <= RESET_MTVEC & ~W'(3);
            mscratch <= '0;
            mepc     <= '0;
            mcause   <= '0;
            mtval    <= '0;
        end else if (commit_valid && exception_valid) begin
            mepc   <= exception_pc & ~W'(3);
            mcause <= exception_cause;
            mtval  <= '0;
            mpie   <= mie;
            mie    <= 1'b0;
            mpp    <= current_privilege;
        end else if (commit_valid && is_mret) begin
            mie  <= mpie;
            mpie <= 1'b1;
            mpp  <= 2'b00;
        end else if (csr_we) begin
            case (csr_addr)
                ADDR_MSTATUS: begin
                    mie  <= new_val[MSTATUS_MIE];
                    mpie <= new_val[MSTATUS_MPIE];
                    // only M and U exist; other MPP encodings are dropped
                    if (new_val[MSTATUS_MPP_HI] == new_val[MSTATUS_MPP_LO])
                        mpp <= new_val[MSTATUS_MPP_HI:MSTATUS_MPP_LO];
                end
                ADDR_MTVEC:    mtvec    <= new_val & ~W'(3);
                ADDR_MSCRATCH: mscratch <= new_val;
                ADDR_MEPC:     mepc     <= new_val & ~W'(3);
                ADDR_MCAUSE:   mcause   <= new_val;
                ADDR_MTVAL:    mtval    <= new_val;
                default: ;
            endcase
        end
    end

    csr_counter64 #(.HALF_WIDTH(W)) u_mcycle (
        .clk    (clk),
        .rst    (rst),
        .inc_en (1'b1),
        .lo_we  (csr_we && csr_addr == ADDR_MCYCLE),
        .hi_we  (csr_we && csr_addr == ADDR_MCYCLEH),
        .wdata  (new_val),
        .count  (mcycle_q)
    );

    csr_counter64 #(.HALF_WIDTH(W)) u_minstret (
        .clk    (clk),
        .rst    (rst),
        .inc_en (commit_valid && !exception_valid),
        .lo_we  (csr_we && csr_addr == ADDR_MINSTRET),
        .hi_we  (csr_we && csr_addr == ADDR_MINSTRETH),
        .wdata  (new_val),
        .count  (minstret_q)
    );

endmodule
